// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array front end.
// Holds the feeder state encoding and the WAIT watchdog margin.
package systolic_pkg;

    localparam int IP_WIDTH_DEF   = 8;
    localparam int PIPE_LAT       = 3;
    localparam int TIMEOUT_MARGIN = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BURST,
        WAIT,
        DONE
    } feeder_state_t;

    function automatic logic len_ok(input int unsigned k, input int unsigned max_k);
        return (k != 0) && (k <= max_k);
    endfunction

endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Operand beat stream into the feeder: one A column vector and one B row vector per beat.
// The source owns valid/data/last; the feeder owns ready.
interface systolic_operand_feeder_if #(
    parameter int ROWS     = 64,
    parameter int COLS     = 64,
    parameter int IP_WIDTH = 8
);
    logic                     s_valid;
    logic                     s_ready;
    logic [ROWS*IP_WIDTH-1:0] s_a;
    logic [COLS*IP_WIDTH-1:0] s_b;
    logic                     s_last;

    modport master (output s_valid, output s_a, output s_b, output s_last, input s_ready);
    modport slave  (input s_valid, input s_a, input s_b, input s_last, output s_ready);
endinterface

// File: rtl/systolic_operand_feeder_tile_buffer.sv
// Flop-based tile store: registered write port, combinational read port.
// Contents are deliberately not reset; pointers in the parent define what is valid.
module feeder_tile_buffer #(
    parameter int DEPTH = 64,
    parameter int W     = 1024,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/systolic_operand_feeder.sv
// Absorbs source bubbles by buffering a whole tile, then replays it to the array as one unbroken en burst.
// Define FEEDER_TIMEOUT_EN to add a watchdog that aborts WAIT if compute_done never rises.
module systolic_operand_feeder
    import systolic_pkg::*;
#(
    parameter int ROWS     = 64,
    parameter int COLS     = 64,
    parameter int IP_WIDTH = IP_WIDTH_DEF,
    parameter int MAX_K    = 64,
    parameter int KW       = $clog2(MAX_K + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    systolic_operand_feeder_if.slave s_if,
    output logic                     arr_en,
    output logic                     arr_clr,
    output logic [ROWS*IP_WIDTH-1:0] arr_input_matrix,
    output logic [COLS*IP_WIDTH-1:0] arr_weight_matrix,
    input  logic                     arr_compute_done,
    input  logic [31:0]              arr_cycles_count,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [31:0]              tile_cycles
);
    localparam int AW   = (MAX_K > 1) ? $clog2(MAX_K) : 1;
    localparam int AWID = ROWS * IP_WIDTH;
    localparam int BWID = COLS * IP_WIDTH;
    localparam int W    = AWID + BWID;

    feeder_state_t   state_q, state_d;
    logic [KW-1:0]   klen_q, klen_d;
    logic [KW-1:0]   wptr_q, wptr_d;
    logic [KW-1:0]   rptr_q, rptr_d;
    logic            cd_prev_q;
    logic            arr_en_q, arr_en_d;
    logic            arr_clr_q, arr_clr_d;
    logic [AWID-1:0] arr_a_q, arr_a_d;
    logic [BWID-1:0] arr_b_q, arr_b_d;
    logic            busy_q, busy_d;
    logic            s_ready_q, s_ready_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [31:0]     tile_cycles_q, tile_cycles_d;

    logic            hs;
    logic            cd_rise;
    logic [W-1:0]    rdata;
    logic [AWID-1:0] rd_a;
    logic [BWID-1:0] rd_b;

`ifdef FEEDER_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(ROWS + COLS + TIMEOUT_MARGIN - 1);
    logic [15:0] wdog_q, wdog_d;
`endif

    feeder_tile_buffer #(
        .DEPTH (MAX_K),
        .W     (W),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (hs),
        .waddr (wptr_q[AW-1:0]),
        .wdata ({s_if.s_a, s_if.s_b}),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rdata)
    );

    assign rd_a    = rdata[W-1 -: AWID];
    assign rd_b    = rdata[BWID-1:0];
    assign hs      = s_if.s_valid && s_ready_q;
    assign cd_rise = arr_compute_done && !cd_prev_q;

    always_comb begin
        state_d       = state_q;
        klen_d        = klen_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        arr_en_d      = 1'b0;
        arr_clr_d     = 1'b0;
        arr_a_d       = '0;
        arr_b_d       = '0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        tile_cycles_d = tile_cycles_q;
`ifdef FEEDER_TIMEOUT_EN
        wdog_d        = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok(32'(k_len), MAX_K)) begin
                        klen_d  = k_len;
                        wptr_d  = '0;
                        rptr_d  = '0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (hs) begin
                    if (wptr_q == klen_q - KW'(1)) begin
                        if (s_if.s_last) begin
                            // Beat 0 launches on the final handshake edge; a 1-beat tile has not landed in the buffer yet.
                            arr_en_d  = 1'b1;
                            arr_clr_d = 1'b1;
                            arr_a_d   = (wptr_q == '0) ? s_if.s_a : rd_a;
                            arr_b_d   = (wptr_q == '0) ? s_if.s_b : rd_b;
                            rptr_d    = KW'(1);
                            state_d   = BURST;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (s_if.s_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wptr_d = wptr_q + KW'(1);
                    end
                end
            end
            BURST: begin
                if (rptr_q < klen_q) begin
                    arr_en_d = 1'b1;
                    arr_a_d  = rd_a;
                    arr_b_d  = rd_b;
                    rptr_d   = rptr_q + KW'(1);
                end else begin
                    state_d = WAIT;
`ifdef FEEDER_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            WAIT: begin
                if (cd_rise) begin
                    tile_cycles_d = arr_cycles_count;
                    done_d        = 1'b1;
                    state_d       = DONE;
                end
`ifdef FEEDER_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d    = (state_d != IDLE);
        s_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            klen_q        <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            cd_prev_q     <= 1'b0;
            arr_en_q      <= 1'b0;
            arr_clr_q     <= 1'b0;
            arr_a_q       <= '0;
            arr_b_q       <= '0;
            busy_q        <= 1'b0;
            s_ready_q     <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            tile_cycles_q <= '0;
`ifdef FEEDER_TIMEOUT_EN
            wdog_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            klen_q        <= klen_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            cd_prev_q     <= arr_compute_done;
            arr_en_q      <= arr_en_d;
            arr_clr_q     <= arr_clr_d;
            arr_a_q       <= arr_a_d;
            arr_b_q       <= arr_b_d;
            busy_q        <= busy_d;
            s_ready_q     <= s_ready_d;
            done_q        <= done_d;
            err_q         <= err_d;
            tile_cycles_q <= tile_cycles_d;
`ifdef FEEDER_TIMEOUT_EN
            wdog_q        <= wdog_d;
`endif
        end
    end

    assign s_if.s_ready      = s_ready_q;
    assign arr_en            = arr_en_q;
    assign arr_clr           = arr_clr_q;
    assign arr_input_matrix  = arr_a_q;
    assign arr_weight_matrix = arr_b_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign tile_cycles       = tile_cycles_q;
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Bench for systolic_operand_feeder with a behavioural systolic array attached (4x4, MAX_K=8).
// Build with +define+FEEDER_TIMEOUT_EN to exercise the watchdog branch.
module tb_systolic_operand_feeder;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int IW = 8;
    localparam int MK = 8;
    localparam int KW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              arr_en, arr_clr;
    logic [R*IW-1:0]   arr_in;
    logic [C*IW-1:0]   arr_w;
    logic              arr_cd;
    logic [31:0]       arr_cnt;
    logic              busy, done, err;
    logic [31:0]       tile_cycles;

    systolic_operand_feeder_if #(.ROWS(R), .COLS(C), .IP_WIDTH(IW)) s_if ();

    systolic_operand_feeder #(.ROWS(R), .COLS(C), .IP_WIDTH(IW), .MAX_K(MK), .KW(KW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .k_len             (k_len),
        .s_if              (s_if),
        .arr_en            (arr_en),
        .arr_clr           (arr_clr),
        .arr_input_matrix  (arr_in),
        .arr_weight_matrix (arr_w),
        .arr_compute_done  (arr_cd),
        .arr_cycles_count  (arr_cnt),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .tile_cycles       (tile_cycles)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [IW-1:0] v);
        return int'($signed(v));
    endfunction

    // Behavioural array: accumulates outer products while en, clr restarts, done rises after a flush delay.
    int acc [R][C];
    int run_cnt;
    bit running;
    int flush;
    bit stub_mode;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) acc[i][j] <= 0;
            run_cnt <= 0; running <= 1'b0; flush <= 0; arr_cd <= 1'b0;
        end else if (arr_en) begin
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++)
                    acc[i][j] <= (arr_clr ? 0 : acc[i][j]) + sx(arr_in[i*IW +: IW]) * sx(arr_w[j*IW +: IW]);
            run_cnt <= arr_clr ? 1 : run_cnt + 1;
            running <= 1'b1; flush <= 0; arr_cd <= 1'b0;
        end else if (running) begin
            if (flush == R + C) begin
                running <= 1'b0;
                arr_cd  <= !stub_mode;
            end else begin
                flush <= flush + 1;
            end
        end
    end
    assign arr_cnt = 32'(run_cnt);

    // Monitor, sampled on the falling edge.
    int cyc = 0, last_hs_cyc = 0, first_en_cyc = 0, en_fall_cyc = 0, en_gap = 0, err_cyc = 0;
    int en_beats, en_runs, done_cnt, err_cnt, clr_bad, idle_bad;
    bit busy_seen, prev_en = 1'b0;
    logic [R*IW-1:0] mon_a [16];
    logic [C*IW-1:0] mon_b [16];
    always @(negedge clk) begin
        cyc++;
        if (s_if.s_valid && s_if.s_ready) last_hs_cyc = cyc;
        if (arr_en) begin
            if (!prev_en) begin
                en_runs++; first_en_cyc = cyc; en_gap = cyc - en_fall_cyc;
            end
            if (en_beats < 16) begin
                mon_a[en_beats] = arr_in; mon_b[en_beats] = arr_w;
            end
            if (arr_clr != (en_beats == 0)) clr_bad++;
            en_beats++;
        end else begin
            if (prev_en) en_fall_cyc = cyc;
            if (arr_clr || arr_in != '0 || arr_w != '0) idle_bad++;
        end
        prev_en = arr_en;
        if (done) done_cnt++;
        if (err) begin err_cnt++; err_cyc = cyc; end
        if (busy) busy_seen = 1'b1;
    end

    int n_checks = 0, n_pass = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic clear_mon();
        en_beats = 0; en_runs = 0; done_cnt = 0; err_cnt = 0;
        clr_bad = 0; idle_bad = 0; busy_seen = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    logic [R*IW-1:0] stim_a [16];
    logic [C*IW-1:0] stim_b [16];

    task automatic do_start(input int k);
        start = 1'b1; k_len = KW'(k);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int nsend, input int last_pos, input int bubble, input int fixed, input int start_busy);
        for (int n = 0; n < nsend; n++) begin
            int nb;
            bit got;
            int t;
            nb = (bubble == 1) ? 1 : (bubble == 2) ? int'($urandom_range(0, 2)) : 0;
            s_if.s_valid = 1'b0;
            for (int b = 0; b < nb; b++) tick();
            stim_a[n] = fixed ? 32'h04030201 : $urandom;
            stim_b[n] = fixed ? 32'h01010101 : $urandom;
            s_if.s_a = stim_a[n]; s_if.s_b = stim_b[n];
            s_if.s_last = (n == last_pos);
            s_if.s_valid = 1'b1;
            if (start_busy != 0 && n == 1) begin
                start = 1'b1; k_len = KW'(2);
            end
            got = 1'b0; t = 0;
            while (!got && t < 50) begin
                @(negedge clk); got = s_if.s_ready;
                tick(); t++;
            end
            start = 1'b0;
            if (!got) chk("handshake_timeout", 0, 1);
        end
        s_if.s_valid = 1'b0; s_if.s_last = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        for (int t = 0; t < bound && done_cnt == 0 && err_cnt == 0; t++) tick();
    endtask

    task automatic check_tile_ok(input int k);
        int dmis, rmis, e;
        dmis = 0; rmis = 0;
        for (int n = 0; n < k && n < 16; n++)
            if (mon_a[n] != stim_a[n] || mon_b[n] != stim_b[n]) dmis++;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                e = 0;
                for (int n = 0; n < k; n++) e += sx(stim_a[n][i*IW +: IW]) * sx(stim_b[n][j*IW +: IW]);
                if (acc[i][j] != e) rmis++;
            end
        chk("en_single_run", en_runs, 1);
        chk("clr_first_only", clr_bad, 0);
        chk("en_after_last_hs", first_en_cyc - last_hs_cyc, 1);
        chk("beat_data_mismatches", dmis, 0);
        chk("array_result_mismatches", rmis, 0);
        chk("tile_cycles", tile_cycles, k);
    endtask

    typedef struct {
        int k; int last_pos; int bubble; int fixed; int start_busy;
        int exp_err; int exp_done; int exp_beats;
    } vec_t;

    initial begin
        vec_t vecs[8];
        bit   prev_ok;
        int   nsend;
        bit   bad_len;
        vecs[0] = '{3, 2, 1, 1, 0, 0, 1, 3};
        vecs[1] = '{0, -1, 0, 0, 0, 1, 0, 0};
        vecs[2] = '{9, -1, 0, 0, 0, 1, 0, 0};
        vecs[3] = '{4, 2, 0, 0, 0, 1, 0, 0};
        vecs[4] = '{4, -1, 2, 0, 0, 1, 0, 0};
        vecs[5] = '{8, 7, 2, 0, 0, 0, 1, 8};
        vecs[6] = '{1, 0, 0, 0, 0, 0, 1, 1};
        vecs[7] = '{5, 4, 2, 0, 1, 0, 1, 5};

        rst = 1'b1; start = 1'b0; k_len = '0; stub_mode = 1'b0;
        s_if.s_valid = 1'b0; s_if.s_a = '0; s_if.s_b = '0; s_if.s_last = 1'b0;
        clear_mon();
        repeat (3) tick();
        chk("rst_arr_en", arr_en, 0);
        chk("rst_arr_clr", arr_clr, 0);
        chk("rst_arr_data", (arr_in != '0) || (arr_w != '0), 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_if.s_ready, 0);
        chk("rst_done_err", done || err, 0);
        chk("rst_tile_cycles", tile_cycles, 0);
        rst = 1'b0;
        repeat (2) tick();

        prev_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clear_mon();
            bad_len = (vecs[i].k < 1) || (vecs[i].k > MK);
            nsend = bad_len ? 0 :
                    (vecs[i].last_pos >= 0 && vecs[i].last_pos < vecs[i].k - 1) ? vecs[i].last_pos + 1 : vecs[i].k;
            do_start(vecs[i].k);
            feed(nsend, vecs[i].last_pos, vecs[i].bubble, vecs[i].fixed, vecs[i].start_busy);
            wait_end(300);
            repeat (3) tick();
            chk($sformatf("v%0d_err_pulses", i), err_cnt, vecs[i].exp_err);
            chk($sformatf("v%0d_done_pulses", i), done_cnt, vecs[i].exp_done);
            chk($sformatf("v%0d_en_beats", i), en_beats, vecs[i].exp_beats);
            chk($sformatf("v%0d_idle_outputs_nonzero", i), idle_bad, 0);
            chk($sformatf("v%0d_busy_after", i), busy, 0);
            if (bad_len) chk($sformatf("v%0d_busy_seen", i), busy_seen, 0);
            if (vecs[i].exp_done != 0) begin
                check_tile_ok(vecs[i].k);
                if (prev_ok) chk($sformatf("v%0d_en_gap_ge2", i), en_gap >= 2, 1);
            end
            prev_ok = (vecs[i].exp_done != 0);
        end

        // Reset asserted while beat 2 of a 5-beat burst is on the outputs.
        clear_mon();
        do_start(5);
        feed(5, 4, 0, 0, 0);
        chk("burst_beat0_en", arr_en, 1);
        tick(); tick();
        chk("burst_beat2_en", arr_en, 1);
        rst = 1'b1;
        #1;
        chk("midrst_arr_en", arr_en, 0);
        chk("midrst_arr_clr", arr_clr, 0);
        chk("midrst_arr_data", (arr_in != '0) || (arr_w != '0), 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tile_cycles", tile_cycles, 0);
        tick();
        @(negedge clk); rst = 1'b0;
        tick();
        clear_mon();
        do_start(2);
        feed(2, 1, 2, 0, 0);
        wait_end(300);
        repeat (3) tick();
        chk("after_rst_done", done_cnt, 1);
        chk("after_rst_err", err_cnt, 0);
        check_tile_ok(2);

        // compute_done never rises.
        stub_mode = 1'b1;
        clear_mon();
        do_start(3);
        feed(3, 2, 0, 0, 0);
        wait_end(60);
`ifdef FEEDER_TIMEOUT_EN
        repeat (3) tick();
        chk("wdog_err_pulses", err_cnt, 1);
        chk("wdog_err_delay", err_cyc - en_fall_cyc, R + C + 16);
        chk("wdog_no_done", done_cnt, 0);
        chk("wdog_busy_after", busy, 0);
        chk("wdog_tile_cycles_held", tile_cycles, 2);
`else
        chk("hang_busy", busy, 1);
        chk("hang_no_err", err_cnt, 0);
        chk("hang_no_done", done_cnt, 0);
        rst = 1'b1; tick(); rst = 1'b0; tick();
`endif
        stub_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
